// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo block: default sizing and the
// pointer-width helper used by the top level and the storage sub-module.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_BUFFER_NO  = 8;

    // Pointer width for a power-of-two depth.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a producer/consumer (master) and the
// FIFO (slave). The sticky error outputs exist only when
// SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  wen;
    logic                  ren;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  half;
    logic                  empty;
    logic [DATA_WIDTH-1:0] data_out;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wen, ren, data_in,
        input  full, half, empty, data_out, overflow, underflow
    );

    modport slave (
        input  wen, ren, data_in,
        output full, half, empty, data_out, overflow, underflow
    );
`else
    modport master (
        output wen, ren, data_in,
        input  full, half, empty, data_out
    );

    modport slave (
        input  wen, ren, data_in,
        output full, half, empty, data_out
    );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// Storage for sync_fifo: one synchronous write port and one synchronous
// read port whose output register is the FIFO's data_out. Only the read
// register is reset; the array itself keeps its contents.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUFFER_NO  = DEFAULT_BUFFER_NO,
    parameter int ADDR_W     = addr_w(BUFFER_NO)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [BUFFER_NO];

    // Write port: store the word at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: register the head word; hold when no read is accepted.
    // On a simultaneous read/write of the same slot (full FIFO) the old
    // word is returned, which is the one at the head of the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/half/empty status. Pointer, occupancy
// count and flag decode live here; storage is in sync_fifo_mem.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow and
// underflow outputs on the bus interface.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUFFER_NO  = DEFAULT_BUFFER_NO
) (
    input logic        clk,
    input logic        reset,
    sync_fifo_if.slave bus
);

    localparam int ADDR_W = addr_w(BUFFER_NO);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BUFFER_NO);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BUFFER_NO / 2);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              write_acc;
    logic              read_acc;
    logic              full_int;
    logic              empty_int;

    // Flags decode the registered count only.
    assign full_int  = (count == CNT_FULL);
    assign empty_int = (count == '0);

    assign bus.full  = full_int;
    assign bus.empty = empty_int;
    assign bus.half  = (count >= CNT_HALF);

    // A full FIFO still takes a write when a read frees the head slot in
    // the same cycle; an empty FIFO never forwards a write straight out.
    assign write_acc = bus.wen && (!full_int || bus.ren);
    assign read_acc  = bus.ren && !empty_int;

    // Pointer and occupancy tracking; power-of-two depth lets the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (read_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + CNT_W'(write_acc) - CNT_W'(read_acc);
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky misuse indicators, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wen && full_int && !bus.ren) begin
                overflow_q <= 1'b1;
            end
            if (bus.ren && empty_int) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUFFER_NO  (BUFFER_NO),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (write_acc && !reset),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (read_acc),
        .raddr (rd_ptr),
        .rdata (bus.data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table walks reset, fill,
// overflow, drain, underflow, empty write+read and mid-operation reset;
// a hand-written sequence covers full-FIFO simultaneous read/write with
// pointer wrap.
module tb_sync_fifo;

    logic clk = 1'b0;
    logic reset;

    sync_fifo_if #(.DATA_WIDTH(8)) bus ();

    sync_fifo #(
        .DATA_WIDTH (8),
        .BUFFER_NO  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wen;
        logic       ren;
        logic [7:0] din;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_half;
        logic [7:0] exp_dout;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic wen, input logic ren,
                                input logic [7:0] din, input logic e, input logic f,
                                input logic h, input logic [7:0] dout,
                                input logic ovf, input logic unf);
        vec_t v;
        v.rst = rst; v.wen = wen; v.ren = ren; v.din = din;
        v.exp_empty = e; v.exp_full = f; v.exp_half = h; v.exp_dout = dout;
        v.exp_ovf = ovf; v.exp_unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and sample just after the rising edge.
    task automatic step(input logic rst, input logic wen, input logic ren, input logic [7:0] din);
        reset       = rst;
        bus.wen     = wen;
        bus.ren     = ren;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic e, input logic f, input logic h);
        check({tag, ".empty"}, {7'd0, bus.empty}, {7'd0, e});
        check({tag, ".full"},  {7'd0, bus.full},  {7'd0, f});
        check({tag, ".half"},  {7'd0, bus.half},  {7'd0, h});
    endtask

    initial begin
        logic [7:0] wr_data [8];
        logic [7:0] exp_q [$];
        logic [7:0] exp_word;

        wr_data = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

        // rst wen ren din | empty full half dout ovf unf
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(0, 1, 0, wr_data[i], 0, (i == 7), (i >= 3), 8'h00, 0, 0));
        end
        vecs.push_back(mk(0, 1, 0, 8'h01, 0, 1, 1, 8'h00, 1, 0));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(0, 0, 1, 8'h00, (i == 7), 0, (i <= 3), wr_data[i], 1, 0));
        end
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 8'h12, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'hAA, 0, 0, 0, 8'h12, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 8'hAA, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h11, 0, 0, 0, 8'hAA, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h22, 0, 0, 0, 8'hAA, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h33, 0, 0, 0, 8'hAA, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h44, 0, 0, 1, 8'hAA, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h55, 0, 0, 1, 8'hAA, 1, 1));
        vecs.push_back(mk(1, 1, 1, 8'h66, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 1));

        reset       = 1'b1;
        bus.wen     = 1'b0;
        bus.ren     = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vecs[i].rst, vecs[i].wen, vecs[i].ren, vecs[i].din);
            check_flags(tag, vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_half);
            check({tag, ".data_out"}, bus.data_out, vecs[i].exp_dout);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            check({tag, ".overflow"},  {7'd0, bus.overflow},  {7'd0, vecs[i].exp_ovf});
            check({tag, ".underflow"}, {7'd0, bus.underflow}, {7'd0, vecs[i].exp_unf});
`endif
        end

        // Full FIFO with simultaneous read/write, then drain across the wrap.
        step(1, 0, 0, 8'h00);
        check_flags("wrap.reset", 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        check_flags("wrap.filled", 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 8'hB0 + 8'(i));
            exp_word = exp_q.pop_front();
            exp_q.push_back(8'hB0 + 8'(i));
            check($sformatf("wrap.rw%0d.data_out", i), bus.data_out, exp_word);
            check_flags($sformatf("wrap.rw%0d", i), 0, 1, 1);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 8'h00);
            exp_word = exp_q.pop_front();
            check($sformatf("wrap.drain%0d.data_out", i), bus.data_out, exp_word);
            check_flags($sformatf("wrap.drain%0d", i), (i == 7), 0, (i <= 3));
        end
        step(0, 0, 1, 8'h00);
        check("wrap.extra_read.data_out", bus.data_out, 8'hB3);
        check_flags("wrap.extra_read", 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
